// File: rtl/sonar_ranger.sv
// Ultrasonic ranger: periodic HC-SR04 trigger, echo pulse timing and conversion of the
// echo width into a saturating 10-bit display position (MAX_POS must not exceed 1023).
module sonar_ranger #(
    parameter int unsigned TRIG_CYCLES     = 500,
    parameter int unsigned PERIOD_CYCLES   = 3000000,
    parameter int unsigned ECHO_TIMEOUT    = 1250000,
    parameter int unsigned CYCLES_PER_STEP = 1813,
    parameter int unsigned MAX_POS         = 639
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       echo,
    output logic       trig,
    output logic [9:0] position,
    output logic       valid,
    output logic       no_echo
);

    localparam int unsigned PRE_W = (CYCLES_PER_STEP > 1) ? $clog2(CYCLES_PER_STEP) : 1;
    localparam int unsigned TMO_W = (ECHO_TIMEOUT > 1) ? $clog2(ECHO_TIMEOUT) : 1;
    localparam int unsigned PER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYCLES_PER_STEP - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ECHO_TIMEOUT - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [PER_W-1:0] TRIG_END = PER_W'(TRIG_CYCLES);
    localparam logic [9:0]       MAX_P    = 10'(MAX_POS);

    localparam logic [1:0] TRIG_S = 2'd0;
    localparam logic [1:0] WAIT_S = 2'd1;
    localparam logic [1:0] MEAS_S = 2'd2;
    localparam logic [1:0] IDLE_S = 2'd3;

    logic             echo_s1_q, echo_s2_q, echo_s3_q;
    logic [1:0]       state_q, state_d;
    logic [PER_W-1:0] period_cnt_q, period_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d, pre_inc;
    logic [9:0]       acc_q, acc_d, acc_inc;
    logic             trig_q, trig_d;
    logic [9:0]       pos_q, pos_d;
    logic             valid_q, valid_d;
    logic             no_echo_q, no_echo_d;
    logic             echo_rise, echo_fall;

    // s1/s2 resynchronise the pin; s3 is only a delay tap for edge detection.
    assign echo_rise = echo_s2_q & ~echo_s3_q;
    assign echo_fall = ~echo_s2_q & echo_s3_q;

    // One prescaler tick; the accumulator advances on wrap and never passes MAX_POS.
    always_comb begin
        pre_inc = pre_cnt_q + 1'b1;
        acc_inc = acc_q;
        if (pre_cnt_q == PRE_LAST) begin
            pre_inc = '0;
            if (acc_q != MAX_P) begin
                acc_inc = acc_q + 10'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        pre_cnt_d    = pre_cnt_q;
        acc_d        = acc_q;
        pos_d        = pos_q;
        valid_d      = 1'b0;
        no_echo_d    = no_echo_q;

        // Saturating at the last count lets an overrunning measurement stretch the period.
        if (period_cnt_q != PER_LAST) begin
            period_cnt_d = period_cnt_q + 1'b1;
        end

        unique case (state_q)
            TRIG_S: begin
                if (period_cnt_q == TRIG_END) begin
                    state_d   = WAIT_S;
                    tmo_cnt_d = '0;
                end
            end
            WAIT_S: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (echo_rise) begin
                    state_d   = MEAS_S;
                    tmo_cnt_d = '0;
                    pre_cnt_d = '0;
                    acc_d     = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = IDLE_S;
                    no_echo_d = 1'b1;
                end
            end
            MEAS_S: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                pre_cnt_d = pre_inc;
                acc_d     = acc_inc;
                if (echo_fall) begin
                    state_d   = IDLE_S;
                    pos_d     = acc_inc;
                    valid_d   = 1'b1;
                    no_echo_d = 1'b0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Echo stuck high: report the far edge.
                    state_d   = IDLE_S;
                    pos_d     = MAX_P;
                    valid_d   = 1'b1;
                    no_echo_d = 1'b0;
                end
            end
            IDLE_S: begin
                if (period_cnt_q == PER_LAST) begin
                    state_d      = TRIG_S;
                    period_cnt_d = '0;
                end
            end
        endcase

        trig_d = (state_q == TRIG_S) && (period_cnt_q != TRIG_END);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            echo_s1_q    <= 1'b0;
            echo_s2_q    <= 1'b0;
            echo_s3_q    <= 1'b0;
            state_q      <= TRIG_S;
            period_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            pre_cnt_q    <= '0;
            acc_q        <= '0;
            trig_q       <= 1'b0;
            pos_q        <= '0;
            valid_q      <= 1'b0;
            no_echo_q    <= 1'b0;
        end else begin
            echo_s1_q    <= echo;
            echo_s2_q    <= echo_s1_q;
            echo_s3_q    <= echo_s2_q;
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            pre_cnt_q    <= pre_cnt_d;
            acc_q        <= acc_d;
            trig_q       <= trig_d;
            pos_q        <= pos_d;
            valid_q      <= valid_d;
            no_echo_q    <= no_echo_d;
        end
    end

    assign trig     = trig_q;
    assign position = pos_q;
    assign valid    = valid_q;
    assign no_echo  = no_echo_q;

endmodule

// File: tb/tb_sonar_ranger.sv
// Bench for sonar_ranger: a per-period behavioural model checked every cycle, plus directed
// literal expectations for each measurement scenario.
module tb_sonar_ranger;

    localparam int unsigned TrigC    = 5;
    localparam int unsigned PeriodC  = 2000;
    localparam int unsigned TimeoutC = 500;
    localparam int unsigned StepC    = 10;
    localparam int unsigned MaxPos   = 20;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       echo;
    logic       trig;
    logic [9:0] position;
    logic       valid;
    logic       no_echo;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rises[$];
    int falls[$];
    logic prev_trig = 1'b0;

    // Expected outputs produced by the model.
    logic m_trig    = 1'b0;
    logic m_valid   = 1'b0;
    logic m_no_echo = 1'b0;
    int   m_pos     = 0;
    bit   m_abort;
    int   m_n;
    bit   hist [4];

    sonar_ranger #(
        .TRIG_CYCLES    (TrigC),
        .PERIOD_CYCLES  (PeriodC),
        .ECHO_TIMEOUT   (TimeoutC),
        .CYCLES_PER_STEP(StepC),
        .MAX_POS        (MaxPos)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .echo    (echo),
        .trig    (trig),
        .position(position),
        .valid   (valid),
        .no_echo (no_echo)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The sensor pin as the ranger sees it: hist[2]/hist[3] are the pin two and three
    // samples back, so a pin edge acts three clocks later.
    task automatic m_tick();
        @(posedge clk);
        if (!reset_n) begin
            m_abort = 1'b1;
            return;
        end
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = echo;
        m_n++;
        m_valid = 1'b0;
    endtask

    // One trigger period after another: pulse, wait for echo, time it, idle out the period.
    task automatic m_run();
        int  k;
        int  j;
        bit  rose;
        hist    = '{default: 1'b0};
        m_abort = 1'b0;
        forever begin
            m_n = 0;
            repeat (TrigC) begin
                m_tick();
                if (m_abort) return;
                m_trig = 1'b1;
            end
            m_tick();
            if (m_abort) return;
            m_trig = 1'b0;
            k    = 0;
            rose = 1'b0;
            while (!rose && k < TimeoutC) begin
                m_tick();
                if (m_abort) return;
                k++;
                rose = hist[2] && !hist[3];
            end
            if (rose) begin
                j = 0;
                forever begin
                    m_tick();
                    if (m_abort) return;
                    j++;
                    if (!hist[2] && hist[3]) begin
                        m_pos = (j / StepC > MaxPos) ? MaxPos : j / StepC;
                        m_valid = 1'b1;
                        m_no_echo = 1'b0;
                        break;
                    end
                    if (j == TimeoutC) begin
                        m_pos = MaxPos;
                        m_valid = 1'b1;
                        m_no_echo = 1'b0;
                        break;
                    end
                end
            end else begin
                m_no_echo = 1'b1;
            end
            do begin
                m_tick();
                if (m_abort) return;
            end while (m_n < PeriodC);
        end
    endtask

    initial begin
        forever begin
            m_trig    = 1'b0;
            m_valid   = 1'b0;
            m_no_echo = 1'b0;
            m_pos     = 0;
            wait (reset_n === 1'b1);
            m_run();
        end
    end

    // Per-cycle comparison against the model, plus trigger edge logging.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (trig === 1'b1 && prev_trig === 1'b0) rises.push_back(cyc);
            if (trig === 1'b0 && prev_trig === 1'b1) falls.push_back(cyc);
            prev_trig = trig;
            n_cmp++;
            if (trig !== m_trig || valid !== m_valid || no_echo !== m_no_echo ||
                position !== 10'(m_pos)) begin
                n_bad++;
                $display("FAIL cycle %0d outputs: got trig=%b valid=%b no_echo=%b pos=%0d, want trig=%b valid=%b no_echo=%b pos=%0d",
                         cyc, trig, valid, no_echo, position, m_trig, m_valid, m_no_echo, m_pos);
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: stimulus did not complete, got %0d compared / %0d bad", n_cmp,
                 n_bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_trig(input string name, input logic lvl, input int limit);
        int i = 0;
        while (trig !== lvl && i < limit) begin
            @(negedge clk);
            i++;
        end
        check(name, int'(trig === lvl), 1);
    endtask

    task automatic wait_trig_fall(input string name);
        wait_trig({name, " trig rise"}, 1'b1, 2500);
        wait_trig({name, " trig fall"}, 1'b0, 20);
    endtask

    task automatic pulse(input int delay, input int width);
        repeat (delay) @(negedge clk);
        echo = 1'b1;
        repeat (width) @(negedge clk);
        echo = 1'b0;
    endtask

    task automatic expect_meas(input string name, input int exp_pos);
        int i = 0;
        while (valid !== 1'b1 && i < 1200) begin
            @(negedge clk);
            i++;
        end
        check({name, " valid"}, int'(valid === 1'b1), 1);
        check({name, " position"}, int'(position), exp_pos);
        check({name, " no_echo"}, int'(no_echo), 0);
        @(negedge clk);
        check({name, " valid one cycle"}, int'(valid), 0);
    endtask

    task automatic expect_timeout(input string name, input int exp_pos);
        int i = 0;
        while (no_echo !== 1'b1 && i < 1200) begin
            @(negedge clk);
            i++;
        end
        check({name, " no_echo"}, int'(no_echo === 1'b1), 1);
        check({name, " position held"}, int'(position), exp_pos);
        check({name, " valid"}, int'(valid), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n = 1'b0;
        echo    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset trig", int'(trig), 0);
        check("reset position", int'(position), 0);
        check("reset valid", int'(valid), 0);
        check("reset no_echo", int'(no_echo), 0);
        reset_n = 1'b1;

        wait_trig_fall("p1");
        pulse(50, 137);
        expect_meas("echo137", 13);

        wait_trig_fall("p2");
        expect_timeout("no_echo", 13);

        wait_trig_fall("p3");
        pulse(20, 40);
        expect_meas("echo40", 4);

        wait_trig_fall("p4");
        pulse(10, 300);
        expect_meas("echo300", 20);
        pulse(100, 30);

        wait_trig_fall("p5");
        pulse(20, 1);
        expect_meas("glitch", 0);

        wait_trig("p6 trig low", 1'b0, 20);
        wait_trig("p6 trig rise", 1'b1, 2500);
        pulse(0, 2);
        expect_timeout("trig_edges", 0);

        wait_trig_fall("p7");
        repeat (15) @(negedge clk);
        echo = 1'b1;
        expect_meas("stuck", 20);

        wait_trig_fall("p8");
        expect_timeout("stuck_no_rise", 20);
        repeat (50) @(negedge clk);
        echo = 1'b0;

        wait_trig_fall("p9");
        repeat (10) @(negedge clk);
        echo = 1'b1;
        repeat (40) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("async reset trig", int'(trig), 0);
        check("async reset position", int'(position), 0);
        check("async reset valid", int'(valid), 0);
        check("async reset no_echo", int'(no_echo), 0);
        echo = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("trig after reset", int'(trig), 1);

        wait_trig_fall("p10");
        pulse(30, 95);
        expect_meas("after_reset", 9);
        repeat (20) @(negedge clk);

        check("trig rise count", rises.size(), 10);
        if (rises.size() >= 9 && falls.size() >= 1) begin
            check("first trig width", falls[0] - rises[0], 5);
            check("first period", rises[1] - rises[0], 2000);
            check("period after stuck echo", rises[8] - rises[7], 2000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
